reg_writeback: RTL and testbench



---
 rtl/reg_writeback.sv | 107 ++++++++++
 tb/tb_reg_writeback.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback.sv
// MIPS register-file write-back: buffers ALU results in a small in-order queue,
// commits one per cycle, and serves two combinational read ports with bypass.
module reg_writeback #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic                         WB_VALID,
   output logic                         WB_READY,
   input  logic [4:0]                   WriteReg,
   input  logic [31:0]                  WriteData,
   input  logic                         DBG_WE,
   input  logic [4:0]                   DBG_ADDR,
   input  logic [31:0]                  DBG_DATA,
   input  logic [4:0]                   ReadReg1,
   input  logic [4:0]                   ReadReg2,
   output logic [31:0]                  A,
   output logic [31:0]                  B,
   output logic [$clog2(DEPTH+1)-1:0]   PENDING,
   output logic [CNT_W-1:0]             COMMIT_CNT
);

   localparam int PW = $clog2(DEPTH + 1);

   logic [31:0]      r_regs [32];
   logic [4:0]       r_qAddr [DEPTH];
   logic [31:0]      r_qData [DEPTH];
   logic [PW-1:0]    r_count;
   logic [CNT_W-1:0] r_commitCnt;

   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [PW-1:0]    w_pushIdx;

   function automatic logic [31:0] resetImage(input int idx);
      case (idx)
         0:       resetImage = 32'd3;
         1:       resetImage = 32'd4;
         2:       resetImage = 32'd1;
         3:       resetImage = 32'd2;
         4:       resetImage = 32'd3;
         6:       resetImage = 32'd5;
         7:       resetImage = 32'hA;
         8:       resetImage = 32'd2;
         9:       resetImage = 32'hD;
         10:      resetImage = 32'hA;
         default: resetImage = 32'd0;
      endcase
   endfunction

   assign w_full    = (r_count == PW'(DEPTH));
   assign WB_READY  = !w_full && !RESET;
   assign w_push    = WB_VALID && WB_READY;
   assign w_pop     = (r_count != '0) && !DBG_WE;
   // After a pop the remaining entries shift down one slot, so the push lands one lower.
   assign w_pushIdx = r_count - PW'(w_pop);

   assign PENDING    = r_count;
   assign COMMIT_CNT = r_commitCnt;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= resetImage(i);
         end
         for (int i = 0; i < DEPTH; i++) begin
            r_qAddr[i] <= '0;
            r_qData[i] <= '0;
         end
         r_count     <= '0;
         r_commitCnt <= '0;
      end else begin
         if (DBG_WE) begin
            r_regs[DBG_ADDR] <= DBG_DATA;
         end else if (w_pop) begin
            r_regs[r_qAddr[0]] <= r_qData[0];
            r_commitCnt        <= r_commitCnt + 1'b1;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (w_pop && (i < DEPTH - 1)) begin
               r_qAddr[i] <= r_qAddr[i + 1];
               r_qData[i] <= r_qData[i + 1];
            end
            if (w_push && (w_pushIdx == PW'(i))) begin
               r_qAddr[i] <= WriteReg;
               r_qData[i] <= WriteData;
            end
         end
         r_count <= r_count + PW'(w_push) - PW'(w_pop);
      end
   end

   // Later slots are younger, so the last match in the scan wins.
   always_comb begin
      A = r_regs[ReadReg1];
      B = r_regs[ReadReg2];
      for (int i = 0; i < DEPTH; i++) begin
         if (PW'(i) < r_count) begin
            if (r_qAddr[i] == ReadReg1) A = r_qData[i];
            if (r_qAddr[i] == ReadReg2) B = r_qData[i];
         end
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback, checked against a queue-based
// reference model of the register file.
module tb_reg_writeback;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } entry_t;

   logic             clock = 1'b0;
   logic             reset;
   logic             wbValid;
   logic             wbReady;
   logic [4:0]       writeReg;
   logic [31:0]      writeData;
   logic             dbgWe;
   logic [4:0]       dbgAddr;
   logic [31:0]      dbgData;
   logic [4:0]       readReg1;
   logic [4:0]       readReg2;
   logic [31:0]      aOut;
   logic [31:0]      bOut;
   logic [1:0]       pending;
   logic [CNT_W-1:0] commitCnt;

   logic [31:0]      mRegs [32];
   entry_t           mQ [$];
   logic [CNT_W-1:0] mCnt;
   bit               modelValid = 0;

   int checks   = 0;
   int failures = 0;

   reg_writeback #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .CLK        (clock),
      .RESET      (reset),
      .WB_VALID   (wbValid),
      .WB_READY   (wbReady),
      .WriteReg   (writeReg),
      .WriteData  (writeData),
      .DBG_WE     (dbgWe),
      .DBG_ADDR   (dbgAddr),
      .DBG_DATA   (dbgData),
      .ReadReg1   (readReg1),
      .ReadReg2   (readReg2),
      .A          (aOut),
      .B          (bOut),
      .PENDING    (pending),
      .COMMIT_CNT (commitCnt)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic void resetModel();
      for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
      mRegs[0] = 32'd3;  mRegs[1] = 32'd4;  mRegs[2] = 32'd1;
      mRegs[3] = 32'd2;  mRegs[4] = 32'd3;  mRegs[6] = 32'd5;
      mRegs[7] = 32'hA;  mRegs[8] = 32'd2;  mRegs[9] = 32'hD;
      mRegs[10] = 32'hA;
      mQ.delete();
      mCnt = '0;
   endfunction

   // Newest pending write to a register is what the decode stage must see.
   function automatic logic [31:0] expRead(input logic [4:0] addr);
      for (int i = mQ.size() - 1; i >= 0; i--) begin
         if (mQ[i].addr == addr) return mQ[i].data;
      end
      return mRegs[addr];
   endfunction

   // Drives one cycle, checks outputs before the edge, then advances the model.
   task automatic applyStimulus(input logic rst, input logic valid, input logic [4:0] wReg,
                                input logic [31:0] wData, input logic dWe, input logic [4:0] dAddr,
                                input logic [31:0] dData, input logic [4:0] rr1, input logic [4:0] rr2);
      bit     ready;
      entry_t e;
      @(negedge clock);
      reset = rst; wbValid = valid; writeReg = wReg; writeData = wData;
      dbgWe = dWe; dbgAddr = dAddr; dbgData = dData; readReg1 = rr1; readReg2 = rr2;
      #1;
      ready = (mQ.size() != DEPTH) && !rst;
      if (modelValid) begin
         checkOutput("A", aOut, expRead(rr1));
         checkOutput("B", bOut, expRead(rr2));
         checkOutput("WB_READY", {31'd0, wbReady}, {31'd0, ready});
         checkOutput("PENDING", {30'd0, pending}, 32'(mQ.size()));
         checkOutput("COMMIT_CNT", {28'd0, commitCnt}, {28'd0, mCnt});
      end
      @(posedge clock);
      if (rst) begin
         resetModel();
         modelValid = 1;
      end else if (modelValid) begin
         if (dWe) begin
            mRegs[dAddr] = dData;
         end else if (mQ.size() > 0) begin
            e = mQ.pop_front();
            mRegs[e.addr] = e.data;
            mCnt = mCnt + 1'b1;
         end
         if (valid && ready) mQ.push_back('{addr: wReg, data: wData});
      end
   endtask

   task automatic idle(input logic [4:0] rr1, input logic [4:0] rr2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, rr1, rr2);
   endtask

   initial begin
      reset = 1; wbValid = 0; writeReg = 0; writeData = 0;
      dbgWe = 0; dbgAddr = 0; dbgData = 0; readReg1 = 0; readReg2 = 0;

      // Reset read-back sweep
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));
      idle(9, 7);
      checkOutput("resetR9", aOut, 32'hD);
      checkOutput("resetR7", bOut, 32'hA);

      // Single write with bypass
      applyStimulus(0, 1, 2, 32'h7, 0, 0, 0, 2, 20);
      #1 checkOutput("bypassR2", aOut, 32'h7);
      idle(2, 2);
      #1 checkOutput("committedR2", aOut, 32'h7);
      checkOutput("cntAfterOne", {28'd0, commitCnt}, 32'd1);

      // Stall with debug write, fill the queue, reject a third request
      applyStimulus(0, 1, 3, 32'h10, 1, 31, 32'h55, 3, 4);
      applyStimulus(0, 1, 4, 32'h11, 1, 31, 32'h55, 3, 4);
      applyStimulus(0, 1, 5, 32'h99, 1, 31, 32'h55, 5, 31);
      #1 checkOutput("fullPending", {30'd0, pending}, 32'd2);
      idle(3, 4);
      idle(3, 4);
      idle(31, 5);
      checkOutput("dbgR31", aOut, 32'h55);

      // Youngest bypass and ordering
      applyStimulus(0, 1, 5, 32'h1, 1, 0, 32'h0, 5, 5);
      applyStimulus(0, 1, 5, 32'h2, 1, 0, 32'h0, 5, 5);
      #1 checkOutput("youngestR5", aOut, 32'h2);
      idle(5, 0);
      idle(5, 0);
      idle(5, 0);

      // Debug write loses to an older pending entry
      applyStimulus(0, 1, 6, 32'hAA, 0, 0, 0, 6, 6);
      applyStimulus(0, 0, 0, 0, 1, 6, 32'hBB, 6, 6);
      idle(6, 6);
      #1 checkOutput("dbgVsPendR6", aOut, 32'hAA);

      // Reset while two entries are pending
      applyStimulus(0, 1, 1, 32'hFF, 1, 31, 32'h1, 1, 8);
      applyStimulus(0, 1, 8, 32'hEE, 1, 31, 32'h1, 1, 8);
      applyStimulus(1, 1, 9, 32'h77, 0, 0, 0, 1, 8);
      #1 checkOutput("rstR1", aOut, 32'd4);
      checkOutput("rstR8", bOut, 32'd2);
      idle(1, 8);
      idle(9, 8);

      // Random traffic; a narrow address range raises bypass and ordering hits
      for (int n = 0; n < 400; n++) begin
         logic [4:0] wr, da, r1, r2;
         wr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
         da = 5'($urandom_range(0, 7));
         r1 = 5'($urandom_range(0, 7));
         r2 = 5'($urandom);
         applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) < 7), wr, $urandom,
                       ($urandom_range(0, 9) < 2), da, $urandom, r1, r2);
      end
      idle(0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
